// File: rtl/common_dffram_1wbnr_pkg.sv
// Shared types for the multi-read DFF RAM.
// COMMON_DFFRAM_1WBNR_BYPASS_EN selects write-first read-during-write.
package common_dffram_1wbnr_pkg;

  typedef enum logic {
    RDW_READ_FIRST,
    RDW_WRITE_FIRST
  } rdw_mode_e;

`ifdef COMMON_DFFRAM_1WBNR_BYPASS_EN
  localparam rdw_mode_e RDW_MODE = RDW_WRITE_FIRST;
`else
  localparam rdw_mode_e RDW_MODE = RDW_READ_FIRST;
`endif

endpackage

// File: rtl/common_dffram_rdport.sv
// One synchronous read port: word mux, optional bypass, output regs.
module common_dffram_rdport
  import common_dffram_1wbnr_pkg::*;
#(
  parameter int DW    = 1,
  parameter int AW    = 1,
  parameter int DEPTH = 1 << AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DEPTH*DW-1:0] mem,
  input  logic              wen,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wbe,
  input  logic [DW-1:0]     wdata,
  input  logic              ren,
  input  logic [AW-1:0]     raddr,
  output logic [DW-1:0]     rdata,
  output logic              rvalid
);

  logic [DW-1:0] words [DEPTH];
  logic [DW-1:0] old;
  logic [DW-1:0] next;
  logic          hit;

  for (genvar i = 0; i < DEPTH; i++) begin : g_w
    assign words[i] = mem[DW*i +: DW];
  end

  assign old = words[raddr];
  assign hit = wen && (waddr == raddr);

  always_comb begin
    next = old;
    if (RDW_MODE == RDW_WRITE_FIRST && hit)
      next = (wdata & wbe) | (old & ~wbe);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= ren;
      if (ren) rdata <= next;
    end
  end

endmodule

// File: rtl/stdmacro_dffbe.sv
// Register word with per-bit enable and synchronous reset value.
module stdmacro_dffbe #(
  parameter int          W           = 1,
  parameter logic [W-1:0] RESET_VALUE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VALUE;
    else       q <= (d & en) | (q & ~en);
  end

endmodule

// File: rtl/common_dffram_1wbnr.sv
// DFF RAM: one bit-enabled write port, NUM_RD registered read ports.
// Read-during-write order set by COMMON_DFFRAM_1WBNR_BYPASS_EN.
module common_dffram_1wbnr
  import common_dffram_1wbnr_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 1,
  parameter int RAM_ADDR_WIDTH = 1,
  parameter int NUM_RD         = 2,
  parameter logic [(RAM_DATA_WIDTH<<RAM_ADDR_WIDTH)-1:0]
    RAM_RESET_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wen,
  input  logic [RAM_ADDR_WIDTH-1:0]        waddr,
  input  logic [RAM_DATA_WIDTH-1:0]        wbe,
  input  logic [RAM_DATA_WIDTH-1:0]        wdata,
  input  logic [NUM_RD-1:0]                ren,
  input  logic [NUM_RD*RAM_ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*RAM_DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]                rvalid
);

  localparam int DW    = RAM_DATA_WIDTH;
  localparam int AW    = RAM_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic [DEPTH*DW-1:0] mem;

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [DW-1:0] en;
    assign en = wbe & {DW{wen && (waddr == AW'(i))}};

    stdmacro_dffbe #(
      .W           (DW),
      .RESET_VALUE (RAM_RESET_VALUE[DW*i +: DW])
    ) u_word (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .d     (wdata),
      .q     (mem[DW*i +: DW])
    );
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    common_dffram_rdport #(
      .DW    (DW),
      .AW    (AW),
      .DEPTH (DEPTH)
    ) u_rd (
      .clk    (clk),
      .reset  (reset),
      .mem    (mem),
      .wen    (wen),
      .waddr  (waddr),
      .wbe    (wbe),
      .wdata  (wdata),
      .ren    (ren[p]),
      .raddr  (raddr[AW*p +: AW]),
      .rdata  (rdata[DW*p +: DW]),
      .rvalid (rvalid[p])
    );
  end

endmodule

// File: tb/tb_common_dffram_1wbnr.sv
// Self-checking bench: reference memory model plus directed vectors.
module tb_common_dffram_1wbnr;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NR = 3;
  localparam int DEPTH = 1 << AW;
  localparam logic [63:0] IMG = 64'h1716151413121110;

`ifdef COMMON_DFFRAM_1WBNR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wbe;
  logic [DW-1:0]    wdata;
  logic [NR-1:0]    ren;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rvalid;

  int checks = 0;
  int errors = 0;

  common_dffram_1wbnr #(
    .RAM_DATA_WIDTH  (DW),
    .RAM_ADDR_WIDTH  (AW),
    .NUM_RD          (NR),
    .RAM_RESET_VALUE (IMG)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .wen    (wen),
    .waddr  (waddr),
    .wbe    (wbe),
    .wdata  (wdata),
    .ren    (ren),
    .raddr  (raddr),
    .rdata  (rdata),
    .rvalid (rvalid)
  );

  always #5 clk = ~clk;

  // Reference model: plain array of words, read result per port.
  logic [DW-1:0] m [DEPTH];
  logic [DW-1:0] old [DEPTH];
  logic [DW-1:0] mrd [NR];
  logic          mrv [NR];
  bit            model_ok = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) m[i] = 8'h10 + 8'(i);
      for (int p = 0; p < NR; p++) begin
        mrd[p] = '0;
        mrv[p] = 1'b0;
      end
      model_ok = 1'b1;
    end else begin
      old = m;
      if (wen)
        for (int b = 0; b < DW; b++)
          if (wbe[b]) m[waddr][b] = wdata[b];
      for (int p = 0; p < NR; p++) begin
        mrv[p] = ren[p];
        if (ren[p])
          mrd[p] = BYP ? m[raddr[AW*p +: AW]] : old[raddr[AW*p +: AW]];
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int p = 0; p < NR; p++) begin
        checks++;
        if (rvalid[p] !== mrv[p] || rdata[DW*p +: DW] !== mrd[p]) begin
          errors++;
          $display("FAIL model port%0d: got v=%b d=%h expected v=%b d=%h",
                   p, rvalid[p], rdata[DW*p +: DW], mrv[p], mrd[p]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p, input logic [AW-1:0] a);
    raddr[AW*p +: AW] = a;
  endtask

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] be,
                    input logic [DW-1:0] d);
    wen = 1'b1; waddr = a; wbe = be; wdata = d;
  endtask

  initial begin
    reset = 1'b1; wen = 1'b0; waddr = '0; wbe = '0; wdata = '0;
    ren = '0; raddr = '0;
    step(); step();
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_rdata", 32'(rdata), 32'h0);

    // Reset image read on two ports
    reset = 1'b0;
    ren = 3'b011; set_ra(0, 3'd5); set_ra(1, 3'd2);
    step();
    chk("img_p0", 32'(rdata[7:0]), 32'h15);
    chk("img_p1", 32'(rdata[15:8]), 32'h12);
    chk("img_valid", 32'(rvalid), 32'h3);
    ren = '0;

    // Bit-enabled writes
    wr(3'd3, 8'hFF, 8'h00); step();
    wr(3'd3, 8'h0F, 8'hAB); step();
    wen = 1'b0; ren = 3'b001; set_ra(0, 3'd3); step();
    chk("be_low", 32'(rdata[7:0]), 32'h0B);
    ren = '0;
    wr(3'd3, 8'hF0, 8'hCD); step();
    wen = 1'b0; ren = 3'b001; step();
    chk("be_high", 32'(rdata[7:0]), 32'hCB);
    ren = '0;

    // Read-during-write collision
    wr(3'd4, 8'hFF, 8'h11); step();
    wr(3'd4, 8'hFF, 8'h77); ren = 3'b001; set_ra(0, 3'd4); step();
    chk("rdw_collide", 32'(rdata[7:0]), BYP ? 32'h77 : 32'h11);
    wen = 1'b0; step();
    chk("rdw_after", 32'(rdata[7:0]), 32'h77);
    ren = '0;

    // Hold with rvalid dropping
    wr(3'd1, 8'hFF, 8'h11); step();
    wen = 1'b0; ren = 3'b010; set_ra(1, 3'd1); step();
    chk("hold_d0", 32'(rdata[15:8]), 32'h11);
    chk("hold_v0", 32'(rvalid[1]), 32'h1);
    ren = '0;
    for (int k = 0; k < 3; k++) begin
      wr(3'd1, 8'hFF, 8'h99 + 8'(k)); step();
      chk("hold_d", 32'(rdata[15:8]), 32'h11);
      chk("hold_v", 32'(rvalid[1]), 32'h0);
    end

    // Reset beats concurrent write/read
    reset = 1'b1; ren = 3'b111; set_ra(0, 3'd0);
    wr(3'd0, 8'hFF, 8'hFF); step();
    chk("rst_mid_v", 32'(rvalid), 32'h0);
    chk("rst_mid_d", 32'(rdata), 32'h0);
    reset = 1'b0; wen = 1'b0; ren = 3'b001; step();
    chk("rst_mid_rd", 32'(rdata[7:0]), 32'h10);

    // Random traffic, checked by the model every cycle
    for (int c = 0; c < 10000; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      wen   = 1'($urandom);
      waddr = AW'($urandom);
      wbe   = ($urandom_range(0, 3) == 0) ? 8'hFF : DW'($urandom);
      wdata = DW'($urandom);
      ren   = NR'($urandom);
      raddr = ($urandom_range(0, 3) == 0) ? {NR{waddr}} : (NR*AW)'($urandom);
      step();
    end
    reset = 1'b0; wen = 1'b0; ren = '0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
